// File: rtl/avmm_lvds_req_framer.sv
// Master-side request framer: turns Avalon-MM read/write commands into a
// header/address/data word stream on the LVDS request link, with read credits.
module avmm_lvds_req_framer #(
  parameter int BURST_W  = 8,
  parameter int MAX_PEND = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        address_i,
  input  logic [BURST_W-1:0] burstcount_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [31:0]        writedata_i,
  input  logic [3:0]         byteenable_i,
  output logic               waitrequest_o,
  input  logic               resp_word_i,
  output logic [31:0]        tx_data_o,
  output logic               tx_valid_o,
  output logic               rd_underflow_o
);

  typedef enum logic [1:0] {IDLE, HDR, ADDR, DATA} state_t;

  state_t             state, state_nxt;
  logic               is_wr;
  logic [31:0]        addr_q;
  logic [BURST_W-1:0] n_q;
  logic [BURST_W-1:0] beats_left;
  logic [3:0]         be_q;
  logic [31:0]        hold;
  logic               hold_vld;
  logic [15:0]        pending;

  logic [BURST_W-1:0] n_in;
  logic [16:0]        pend_sum;
  logic               rd_ok;
  logic               acc_wr, acc_rd, beat_ld;
  logic [31:0]        hdr;

  assign n_in     = (burstcount_i == '0) ? BURST_W'(1) : burstcount_i;
  assign pend_sum = {1'b0, pending} + 17'(n_in);
  assign rd_ok    = (pend_sum <= 17'(MAX_PEND));

  always_comb begin
    hdr = '0;
    hdr[31:30] = is_wr ? 2'b01 : 2'b10;
    hdr[27:24] = be_q;
    hdr[BURST_W-1:0] = n_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    waitrequest_o = 1'b1;
    tx_valid_o    = 1'b0;
    tx_data_o     = '0;
    acc_wr        = 1'b0;
    acc_rd        = 1'b0;
    beat_ld       = 1'b0;
    case (state)
      IDLE: begin
        // Write wins if a master illegally raises both strobes.
        if (write_i) begin
          waitrequest_o = 1'b0;
          acc_wr        = 1'b1;
          state_nxt     = HDR;
        end else if (read_i && rd_ok) begin
          waitrequest_o = 1'b0;
          acc_rd        = 1'b1;
          state_nxt     = HDR;
        end
      end
      HDR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = hdr;
        state_nxt  = ADDR;
      end
      ADDR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = addr_q;
        state_nxt  = is_wr ? DATA : IDLE;
      end
      DATA: begin
        // Holding register drains and refills in the same cycle when streaming.
        waitrequest_o = (beats_left == '0);
        beat_ld       = write_i && (beats_left != '0);
        tx_valid_o    = hold_vld;
        tx_data_o     = hold_vld ? hold : 32'h0;
        if (hold_vld && beats_left == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      is_wr      <= 1'b0;
      addr_q     <= '0;
      n_q        <= '0;
      be_q       <= '0;
      hold       <= '0;
      hold_vld   <= 1'b0;
      beats_left <= '0;
    end else if (acc_wr || acc_rd) begin
      is_wr      <= acc_wr;
      addr_q     <= address_i;
      n_q        <= n_in;
      be_q       <= byteenable_i;
      hold       <= writedata_i;
      hold_vld   <= acc_wr;
      beats_left <= n_in - BURST_W'(1);
    end else if (beat_ld) begin
      hold       <= writedata_i;
      hold_vld   <= 1'b1;
      beats_left <= beats_left - BURST_W'(1);
    end else if (state == DATA) begin
      hold_vld   <= 1'b0;
    end
  end

  // Read credits: a returned word releases one, a read accept reserves N.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending        <= '0;
      rd_underflow_o <= 1'b0;
    end else begin
      case ({acc_rd, resp_word_i})
        2'b10: pending <= pending + 16'(n_in);
        2'b11: pending <= pending + 16'(n_in) - 16'd1;
        2'b01: begin
          if (pending == '0) rd_underflow_o <= 1'b1;
          else               pending <= pending - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_lvds_req_framer.sv
// Self-checking bench for avmm_lvds_req_framer: table vectors, directed
// corner sequences and randomized commands against a frame/credit model.
module tb_avmm_lvds_req_framer;
  localparam int BW = 8;
  localparam int MP = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [31:0]   address_i;
  logic [BW-1:0] burstcount_i;
  logic          read_i, write_i;
  logic [31:0]   writedata_i;
  logic [3:0]    byteenable_i;
  logic          waitrequest_o;
  logic          resp_word_i;
  logic [31:0]   tx_data_o;
  logic          tx_valid_o;
  logic          rd_underflow_o;

  avmm_lvds_req_framer #(.BURST_W(BW), .MAX_PEND(MP)) dut (
    .clk_i(clk), .rst_i(rst_i), .address_i(address_i), .burstcount_i(burstcount_i),
    .read_i(read_i), .write_i(write_i), .writedata_i(writedata_i),
    .byteenable_i(byteenable_i), .waitrequest_o(waitrequest_o),
    .resp_word_i(resp_word_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .rd_underflow_o(rd_underflow_o));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, wrq_lo = 0;
  int pend_m = 0;
  logic [31:0] got[$];
  int          gcyc[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    #1;
    cyc++;
    if (tx_valid_o) begin
      got.push_back(tx_data_o);
      gcyc.push_back(cyc);
    end
    if (!waitrequest_o) wrq_lo++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Returns at the negedge following the accepting posedge.
  task automatic wait_accept(input string nm);
    int t = 0;
    #1;
    while (waitrequest_o && t < 200) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 200) chk({nm, " accept timeout"}, 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input int bc, input int n, input logic [3:0] be,
                    input logic [31:0] d0, input int gap_at, input int gap_len);
    for (int b = 0; b < n; b++) begin
      address_i = a; burstcount_i = BW'(bc); byteenable_i = be;
      writedata_i = d0 + b; write_i = 1'b1;
      wait_accept("write");
      write_i = 1'b0;
      if (b == gap_at) repeat (gap_len) @(negedge clk);
    end
  endtask

  task automatic rd(input logic [31:0] a, input int bc, input logic [3:0] be);
    address_i = a; burstcount_i = BW'(bc); byteenable_i = be; read_i = 1'b1;
    wait_accept("read");
    read_i = 1'b0;
  endtask

  task automatic pulse(input int k);
    for (int i = 0; i < k; i++) begin
      resp_word_i = 1'b1;
      @(negedge clk);
      resp_word_i = 1'b0;
    end
  endtask

  // Expected link words for one command, from the frame format rules.
  task automatic model_frame(input bit w, input logic [31:0] a, input int n,
                             input logic [3:0] be, input logic [31:0] d0);
    exp_q.push_back({(w ? 2'b01 : 2'b10), 2'b00, be, 16'h0, 8'(n)});
    exp_q.push_back(a);
    if (w) for (int b = 0; b < n; b++) exp_q.push_back(d0 + b);
  endtask

  task automatic cmp_frame(input string nm);
    int t = 0;
    while (got.size() < exp_q.size() && t < 500) begin
      @(negedge clk); t++;
    end
    repeat (3) @(negedge clk);
    chk({nm, " word count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s word %0d", nm, i), got[i], exp_q[i]);
  endtask

  task automatic clr();
    got.delete(); gcyc.delete(); exp_q.delete();
  endtask

  typedef struct {
    bit          w;
    logic [31:0] addr;
    int          bc;
    logic [3:0]  be;
    logic [31:0] d0;
    logic [31:0] hdr;
  } vec_t;

  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b1, 32'h0003_1000, 1,  4'hF, 32'hCAFE_0123, 32'h4F00_0001};
    vt[1] = '{1'b0, 32'h0020_4000, 8,  4'hF, 32'h0,         32'h8F00_0008};
    vt[2] = '{1'b1, 32'h0000_0010, 0,  4'h5, 32'h0000_0011, 32'h4500_0001};
    vt[3] = '{1'b0, 32'h0000_0020, 0,  4'hA, 32'h0,         32'h8A00_0001};
    vt[4] = '{1'b1, 32'hFFFF_FFFC, 3,  4'h0, 32'h0000_00A0, 32'h4000_0003};
    vt[5] = '{1'b0, 32'h0000_1234, 16, 4'h1, 32'h0,         32'h8100_0010};

    rst_i = 1'b1; address_i = '0; burstcount_i = '0; read_i = 1'b0; write_i = 1'b0;
    writedata_i = '0; byteenable_i = '0; resp_word_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset tx_valid", tx_valid_o, 0);
    chk("reset tx_data", tx_data_o, 0);
    chk("reset waitrequest", waitrequest_o, 1);
    chk("reset underflow", rd_underflow_o, 0);
    chk("reset pending", dut.pending, 0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    clr();

    // Table vectors.
    foreach (vt[k]) begin
      int n;
      n = (vt[k].bc == 0) ? 1 : vt[k].bc;
      wrq_lo = 0;
      exp_q.push_back(vt[k].hdr);
      exp_q.push_back(vt[k].addr);
      if (vt[k].w) begin
        for (int b = 0; b < n; b++) exp_q.push_back(vt[k].d0 + b);
        wr(vt[k].addr, vt[k].bc, n, vt[k].be, vt[k].d0, -1, 0);
      end else begin
        rd(vt[k].addr, vt[k].bc, vt[k].be);
      end
      cmp_frame($sformatf("vec%0d", k));
      for (int i = 1; i < gcyc.size(); i++)
        chk($sformatf("vec%0d consecutive %0d", k, i), gcyc[i] - gcyc[0], i);
      if (k == 0) chk("vec0 waitrequest low cycles", wrq_lo, 1);
      if (!vt[k].w) begin
        chk($sformatf("vec%0d pending", k), dut.pending, n);
        pulse(n);
        chk($sformatf("vec%0d pending drained", k), dut.pending, 0);
      end
      clr();
    end

    // Write burst of 4 with a 2-cycle stall after beat 1.
    model_frame(1'b1, 32'h0000_8000, 4, 4'hF, 32'h1000_0000);
    wr(32'h0000_8000, 4, 4, 4'hF, 32'h1000_0000, 1, 2);
    cmp_frame("gap burst");
    begin
      int offs[6] = '{0, 1, 2, 3, 6, 7};
      for (int i = 0; i < 6 && i < gcyc.size(); i++)
        chk($sformatf("gap burst cycle %0d", i), gcyc[i] - gcyc[0], offs[i]);
    end
    clr();

    // Credit limit: 10 outstanding, second 10 stalls until 4 words return.
    model_frame(1'b0, 32'h0000_0100, 10, 4'hF, 0);
    model_frame(1'b0, 32'h0000_0200, 10, 4'hF, 0);
    rd(32'h0000_0100, 10, 4'hF);
    repeat (3) @(negedge clk);
    address_i = 32'h0000_0200; burstcount_i = 8'd10; read_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("credit stall %0d", k), waitrequest_o, 1);
      resp_word_i = 1'b1;
      @(negedge clk);
      resp_word_i = 1'b0;
    end
    chk("credit pending before accept", dut.pending, 6);
    resp_word_i = 1'b1;
    #1;
    chk("credit accept", waitrequest_o, 0);
    @(negedge clk);
    resp_word_i = 1'b0; read_i = 1'b0;
    chk("credit same-cycle pulse", dut.pending, 15);
    cmp_frame("credit frames");
    clr();
    pulse(15);
    chk("credit drained", dut.pending, 0);

    // Underflow is sticky and never wraps the counter.
    pulse(1);
    chk("underflow set", rd_underflow_o, 1);
    chk("underflow pending", dut.pending, 0);
    repeat (5) @(negedge clk);
    chk("underflow sticky", rd_underflow_o, 1);

    // Reset in the middle of a write burst of 8.
    model_frame(1'b0, 32'h0000_0040, 4, 4'hF, 0);
    rd(32'h0000_0040, 4, 4'hF);
    cmp_frame("pre-reset read");
    clr();
    for (int b = 0; b < 4; b++) begin
      address_i = 32'h0000_9000; burstcount_i = 8'd8; byteenable_i = 4'hF;
      writedata_i = 32'h5500_0000 + b; write_i = 1'b1;
      wait_accept("reset burst");
    end
    write_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    #1;
    chk("mid reset tx_valid", tx_valid_o, 0);
    chk("mid reset waitrequest", waitrequest_o, 1);
    chk("mid reset pending", dut.pending, 0);
    chk("mid reset underflow", rd_underflow_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    clr();
    model_frame(1'b0, 32'h0055_0000, 1, 4'h3, 0);
    rd(32'h0055_0000, 1, 4'h3);
    cmp_frame("post-reset read");
    clr();
    pulse(1);

    // Randomized commands against the frame and credit model.
    pend_m = 0;
    for (int it = 0; it < 30; it++) begin
      bit w;
      int n, bc, ga, gl, k;
      logic [31:0] a, d0;
      logic [3:0] be;
      w  = 1'($urandom_range(0, 1));
      n  = w ? $urandom_range(1, 6) : $urandom_range(1, 8);
      bc = (n == 1 && $urandom_range(0, 1) == 1) ? 0 : n;
      a  = $urandom; d0 = $urandom; be = 4'($urandom);
      ga = $urandom_range(0, 5); gl = $urandom_range(0, 2);
      if (!w && pend_m + n > MP) begin
        pulse(pend_m);
        pend_m = 0;
      end
      model_frame(w, a, n, be, d0);
      if (w) wr(a, bc, n, be, d0, ga, gl);
      else begin
        rd(a, bc, be);
        pend_m += n;
      end
      cmp_frame($sformatf("rand%0d", it));
      clr();
      k = $urandom_range(0, pend_m);
      pulse(k);
      pend_m -= k;
      chk($sformatf("rand%0d pending", it), dut.pending, pend_m);
    end
    chk("rand no underflow", rd_underflow_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
